hex_page_sequencer: RTL

//  Upstream feeder of the DE10 7-segment indicator. Selects one of NUM_PAGES 8-bit status bytes and drives the indicator's two 32-bit input words.
//  - Page index goes to the decimal (ones/tens) digits through out_reg1.
//  - Selected byte, converted to packed BCD by a sequential double-dabble, goes to the nibble digits through out_reg2.

---
 rtl/hex_page_sequencer_pkg.sv | 23 ++
 rtl/hex_page_sequencer_key_debouncer.sv | 49 ++++
 rtl/hex_page_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hex_page_sequencer_pkg.sv
// Shared constants, FSM encoding and BCD helper for the 7-segment page sequencer.
package hex_page_sequencer_pkg;

  localparam logic [7:0]  DISP_OVF_BCD = 8'hFF;
  localparam int unsigned PAGE_W       = 4;

  typedef enum logic [1:0] {
    HPS_IDLE  = 2'd0,
    HPS_SHIFT = 2'd1,
    HPS_LOAD  = 2'd2
  } hps_state_e;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [11:0] bcd_add3(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int unsigned i = 0; i < 3; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_page_sequencer_key_debouncer.sv
// Raw active-low key -> 2-FF synchroniser -> ms-based stability filter -> press pulse.
module key_debouncer
  import hex_page_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;
  logic          key_s;

  assign key_s   = sync_q[1];
  assign press_o = press_q;

  // Counter clears whenever the synchronised key agrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      press_q <= 1'b0;
      if (key_s == level_q) begin
        cnt_q <= '0;
      end else if (ms_tick_i) begin
        if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
          cnt_q   <= '0;
          level_q <= key_s;
          press_q <= ~key_s;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hex_page_sequencer.sv
// Page selector feeding the DE10 7-segment indicator: dwell rotation, key paging,
// and a sequential double-dabble converting the selected byte to packed BCD.
module hex_page_sequencer
  import hex_page_sequencer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned NUM_PAGES   = 4,
  parameter int unsigned DWELL_MS    = 1000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PAGES*8-1:0] page_data,
  input  logic                   key_next_n,
  input  logic                   key_hold_n,
  output logic [31:0]            out_reg1,
  output logic [31:0]            out_reg2,
  output logic                   frozen,
  output logic                   conv_busy
);

  localparam int unsigned PRESC = CLK_FREQ_HZ / 1000;
  localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned DW    = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;

  logic [1:0] rst_sync_q;
  logic       rst_core_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_core_n = rst_sync_q[1];

  logic [PW-1:0] presc_q;
  logic          ms_tick;

  assign ms_tick = (presc_q == PW'(PRESC - 1));

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) presc_q <= '0;
    else             presc_q <= ms_tick ? '0 : presc_q + 1'b1;
  end

  logic next_evt;
  logic hold_evt;

  key_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_next (
    .clk       (clk),
    .rst_n     (rst_core_n),
    .ms_tick_i (ms_tick),
    .key_n_i   (key_next_n),
    .press_o   (next_evt)
  );

  key_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_hold (
    .clk       (clk),
    .rst_n     (rst_core_n),
    .ms_tick_i (ms_tick),
    .key_n_i   (key_hold_n),
    .press_o   (hold_evt)
  );

  logic [PAGE_W-1:0] page_q, page_d, page_seen_q;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic              frozen_q, frozen_d;
  logic              auto_adv;
  logic              page_chg;

  // Manual and automatic advance share one increment, so a coincident pair steps once.
  always_comb begin
    page_d   = page_q;
    dwell_d  = dwell_q;
    frozen_d = frozen_q;
    auto_adv = 1'b0;
    if (!frozen_q && ms_tick) begin
      if (dwell_q == DW'(DWELL_MS - 1)) begin
        dwell_d  = '0;
        auto_adv = 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    if (next_evt || hold_evt) dwell_d = '0;
    if (hold_evt) frozen_d = ~frozen_q;
    if (next_evt || auto_adv) begin
      page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      page_q      <= '0;
      page_seen_q <= '0;
      dwell_q     <= '0;
      frozen_q    <= 1'b0;
    end else begin
      page_q      <= page_d;
      page_seen_q <= page_q;
      dwell_q     <= dwell_d;
      frozen_q    <= frozen_d;
    end
  end

  assign page_chg = (page_q != page_seen_q);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = '0;
    for (int unsigned p = 0; p < NUM_PAGES; p++) begin
      if (page_q == PAGE_W'(p)) sel_byte = page_data[8*p +: 8];
    end
  end

  hps_state_e        state_q, state_d;
  logic              pend_q, pend_d;
  logic [7:0]        bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [2:0]        shift_cnt_q, shift_cnt_d;
  logic [PAGE_W-1:0] idx_q, idx_d;
  logic [PAGE_W-1:0] oidx_q, oidx_d;
  logic [7:0]        obcd_q, obcd_d;
  logic              start_req;
  logic [11:0]       bcd_adj;

  // Index and byte are captured together at start and published together in LOAD.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    shift_cnt_d = shift_cnt_q;
    idx_d       = idx_q;
    oidx_d      = oidx_q;
    obcd_d      = obcd_q;
    start_req   = ms_tick | page_chg;
    bcd_adj     = bcd_add3(bcd_q);
    unique case (state_q)
      HPS_IDLE: begin
        if (start_req || pend_q) begin
          state_d     = HPS_SHIFT;
          pend_d      = 1'b0;
          bin_d       = sel_byte;
          bcd_d       = '0;
          shift_cnt_d = '0;
          idx_d       = page_q;
        end
      end
      HPS_SHIFT: begin
        if (start_req) pend_d = 1'b1;
        bcd_d = {bcd_adj[10:0], bin_q[7]};
        bin_d = {bin_q[6:0], 1'b0};
        if (shift_cnt_q == 3'd7) state_d = HPS_LOAD;
        else                     shift_cnt_d = shift_cnt_q + 1'b1;
      end
      HPS_LOAD: begin
        if (start_req) pend_d = 1'b1;
        state_d = HPS_IDLE;
        oidx_d  = idx_q;
        obcd_d  = (bcd_q[11:8] != 4'd0) ? DISP_OVF_BCD : bcd_q[7:0];
      end
      default: state_d = HPS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q     <= HPS_IDLE;
      pend_q      <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
      idx_q       <= '0;
      oidx_q      <= '0;
      obcd_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      shift_cnt_q <= shift_cnt_d;
      idx_q       <= idx_d;
      oidx_q      <= oidx_d;
      obcd_q      <= obcd_d;
    end
  end

  assign out_reg1  = {28'd0, oidx_q};
  assign out_reg2  = {24'd0, obcd_q};
  assign frozen    = frozen_q;
  assign conv_busy = (state_q != HPS_IDLE);

endmodule
